// File: rtl/sram_ctrl_pkg.sv
// Shared types for the single-port SRAM controller: FSM state encoding and
// the cen/wen/oen strobe patterns driven onto the SRAM pins.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_INIT = 2'd3
   } state_t;

   typedef struct packed {
      logic cen;
      logic wen;
      logic oen;
   } strobe_t;

   localparam strobe_t STB_WRITE = 3'b110;
   localparam strobe_t STB_READ  = 3'b101;
   localparam strobe_t STB_NOP   = 3'b000;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_ctrl_agen.sv
// Burst address generator: loads a start address, increments with natural
// wrap at 2**AW, and counts beats 0..len with last-beat and all-issued flags.
module sram_ctrl_agen #(
   parameter int            AW      = 5,
   parameter int            CW      = 5,
   parameter logic [CW-1:0] RST_LEN = '1
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_load,
   input  logic [AW-1:0] i_start,
   input  logic [CW-1:0] i_len,
   input  logic          i_step,
   output logic [AW-1:0] o_addr,
   output logic          o_last,
   output logic          o_done
);

   logic [AW-1:0] r_addr;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_len;
   logic          r_done;

   // Reset length lets the post-reset memory sweep start without a load.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_len  <= RST_LEN;
         r_done <= 1'b0;
      end else if (i_load) begin
         r_addr <= i_start;
         r_cnt  <= '0;
         r_len  <= i_len;
         r_done <= 1'b0;
      end else if (i_step) begin
         r_addr <= r_addr + AW'(1);
         r_cnt  <= r_cnt + CW'(1);
         if (r_cnt == r_len) r_done <= 1'b1;
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_cnt == r_len);
   assign o_done = r_done;

endmodule

// File: rtl/spsram_ctrl.sv
// Single-port SRAM burst controller (valid/ready front end, registered SRAM pins).
// Define SRAM_CTRL_INIT_EN to zero-fill the whole SRAM after every reset.
module spsram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int LW = 4
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_wr,
   input  logic [AW-1:0] i_req_addr,
   input  logic [LW-1:0] i_req_len,
   input  logic          i_wdata_valid,
   output logic          o_wdata_ready,
   input  logic [DW-1:0] i_wdata,
   output logic          o_rdata_valid,
   input  logic          i_rdata_ready,
   output logic [DW-1:0] o_rdata,
   output logic          o_busy,
   output logic          o_init_done,
   output logic          o_sram_cen,
   output logic          o_sram_wen,
   output logic          o_sram_oen,
   output logic [AW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_data,
   input  logic [DW-1:0] i_sram_data
);

   localparam int CW = max_w(AW, LW);
`ifdef SRAM_CTRL_INIT_EN
   localparam state_t RESET_STATE = ST_INIT;
`else
   localparam state_t RESET_STATE = ST_IDLE;
`endif

   state_t        r_state, w_state_next;
   strobe_t       r_stb, w_stb;
   logic [AW-1:0] r_sram_addr, w_sram_addr;
   logic [DW-1:0] r_sram_data, w_sram_data;
   logic          r_req_ready, r_wdata_ready, r_rdata_valid, r_rd_pend;
   logic [DW-1:0] r_rdata;
   logic          w_req_hs, w_wr_hs, w_rd_hs, w_rd_idle;
   logic          w_ag_load, w_ag_step, w_ag_last, w_ag_done;
   logic [AW-1:0] w_ag_addr;

   sram_ctrl_agen #(
      .AW      (AW),
      .CW      (CW),
      .RST_LEN (CW'((2 ** AW) - 1))
   ) u_agen (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_load  (w_ag_load),
      .i_start (i_req_addr),
      .i_len   (CW'(i_req_len)),
      .i_step  (w_ag_step),
      .o_addr  (w_ag_addr),
      .o_last  (w_ag_last),
      .o_done  (w_ag_done)
   );

   assign w_req_hs  = i_req_valid & r_req_ready;
   assign w_wr_hs   = i_wdata_valid & r_wdata_ready;
   assign w_rd_hs   = r_rdata_valid & i_rdata_ready;
   // No read strobe on the pins and none waiting for its data word.
   assign w_rd_idle = ~r_stb.cen & ~r_rd_pend;

   always_comb begin
      w_state_next = r_state;
      w_stb        = STB_NOP;
      w_sram_addr  = '0;
      w_sram_data  = '0;
      w_ag_load    = 1'b0;
      w_ag_step    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_hs) begin
               w_ag_load    = 1'b1;
               w_state_next = i_req_wr ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
            if (w_wr_hs) begin
               w_stb       = STB_WRITE;
               w_sram_addr = w_ag_addr;
               w_sram_data = i_wdata;
               w_ag_step   = 1'b1;
               if (w_ag_last) w_state_next = ST_IDLE;
            end
         end
         ST_RD: begin
            if (!w_ag_done && w_rd_idle && (!r_rdata_valid || w_rd_hs)) begin
               w_stb       = STB_READ;
               w_sram_addr = w_ag_addr;
               w_ag_step   = 1'b1;
            end
            if (w_rd_hs && w_ag_done && w_rd_idle) w_state_next = ST_IDLE;
         end
`ifdef SRAM_CTRL_INIT_EN
         ST_INIT: begin
            if (!w_ag_done) begin
               w_stb       = STB_WRITE;
               w_sram_addr = w_ag_addr;
               w_ag_step   = 1'b1;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Readies are registered from the next state so they are low in reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state       <= RESET_STATE;
         r_stb         <= STB_NOP;
         r_sram_addr   <= '0;
         r_sram_data   <= '0;
         r_req_ready   <= 1'b0;
         r_wdata_ready <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_rdata       <= '0;
         r_rd_pend     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_stb         <= w_stb;
         r_sram_addr   <= w_sram_addr;
         r_sram_data   <= w_sram_data;
         r_req_ready   <= (w_state_next == ST_IDLE);
         r_wdata_ready <= (w_state_next == ST_WR);
         r_rd_pend     <= r_stb.cen & ~r_stb.wen;
         if (r_rd_pend) begin
            r_rdata       <= i_sram_data;
            r_rdata_valid <= 1'b1;
         end else if (w_rd_hs) begin
            r_rdata_valid <= 1'b0;
         end
      end
   end

`ifdef SRAM_CTRL_INIT_EN
   logic r_init_done;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_init_done <= 1'b0;
      else if (r_state == ST_INIT && w_ag_done) r_init_done <= 1'b1;
   end

   assign o_init_done = r_init_done;
`else
   assign o_init_done = 1'b1;
`endif

   assign o_req_ready   = r_req_ready;
   assign o_wdata_ready = r_wdata_ready;
   assign o_rdata_valid = r_rdata_valid;
   assign o_rdata       = r_rdata;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_sram_cen    = r_stb.cen;
   assign o_sram_wen    = r_stb.wen;
   assign o_sram_oen    = r_stb.oen;
   assign o_sram_addr   = r_sram_addr;
   assign o_sram_data   = r_sram_data;

endmodule

// File: tb/tb_spsram_ctrl.sv
// Bench for spsram_ctrl: table of bursts, hand-written reset/stall cases and
// random bursts, checked against a word-array memory model and strobe log.
module tb_spsram_ctrl;

   typedef struct {
      bit          wr;
      int          addr;
      int          len;
      logic [31:0] base;
      int          stall_beat;
      int          stall_cyc;
      int          exp_beats;
      int          exp_last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_req_valid = 1'b0, i_req_wr = 1'b0;
   logic [4:0]  i_req_addr = '0;
   logic [3:0]  i_req_len = '0;
   logic        i_wdata_valid = 1'b0, i_rdata_ready = 1'b0;
   logic [31:0] i_wdata = '0;
   logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_busy, o_init_done;
   logic        o_sram_cen, o_sram_wen, o_sram_oen;
   logic [4:0]  o_sram_addr;
   logic [31:0] o_sram_data, o_rdata;
   logic [31:0] sram_q = '0;
   logic [31:0] mem [32];

   int          checks = 0, errors = 0, cyc = 0;
   logic [31:0] ref_mem [32];
   bit          known [32];
   int          log_addr [$];
   logic [31:0] log_data [$];
   bit          log_wen [$];
   vec_t        tbl [10];

   spsram_ctrl #(.DW(32), .AW(5), .LW(4)) dut (
      .i_clk(clk), .i_rstn(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wr(i_req_wr),
      .i_req_addr(i_req_addr), .i_req_len(i_req_len),
      .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
      .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
      .o_busy(o_busy), .o_init_done(o_init_done),
      .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_oen(o_sram_oen),
      .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .i_sram_data(sram_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM macro: write at the sampling edge, read word valid one cycle later.
   always @(posedge clk) begin
      if (o_sram_cen && o_sram_wen) mem[o_sram_addr] <= o_sram_data;
      if (o_sram_cen && !o_sram_wen) sram_q <= mem[o_sram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("strobe_pattern",
             {29'd0, ({o_sram_cen, o_sram_wen, o_sram_oen} inside {3'b000, 3'b110, 3'b101})}, 1);
         if (o_sram_cen) begin
            log_addr.push_back(int'(o_sram_addr));
            log_data.push_back(o_sram_data);
            log_wen.push_back(o_sram_wen);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_wen.delete();
   endtask

   task automatic do_req(input bit wr, input int addr, input int len);
      int t = 0;
      i_req_valid = 1'b1;
      i_req_wr    = wr;
      i_req_addr  = 5'(addr);
      i_req_len   = 4'(len);
      while (!o_req_ready && t < 100) begin tick(); t++; end
      chk("req_ready", {31'd0, o_req_ready}, 1);
      tick();
      i_req_valid = 1'b0;
      chk("busy_after_req", {31'd0, o_busy}, 1);
   endtask

   task automatic do_write(input vec_t v, input bit rnd);
      logic [31:0] d [$];
      int          t;
      clear_log();
      do_req(1'b1, v.addr, v.len);
      for (int i = 0; i <= v.len; i++) begin
         d.push_back(rnd ? $urandom : v.base + 32'(i));
         if (rnd) repeat ($urandom_range(0, 2)) tick();
         i_wdata_valid = 1'b1;
         i_wdata       = d[i];
         t = 0;
         while (!o_wdata_ready && t < 100) begin tick(); t++; end
         chk("wdata_ready", {31'd0, o_wdata_ready}, 1);
         tick();
         i_wdata_valid = 1'b0;
      end
      chk("wr_end_busy", {31'd0, o_busy}, 0);
      chk("wr_end_req_ready", {31'd0, o_req_ready}, 1);
      repeat (2) tick();
      chk("wr_strobe_count", log_addr.size(), v.exp_beats);
      if (log_addr.size() > 0) chk("wr_last_addr", log_addr[$], v.exp_last);
      for (int i = 0; i < log_addr.size() && i <= v.len; i++) begin
         chk("wr_addr", log_addr[i], (v.addr + i) % 32);
         chk("wr_data", log_data[i], d[i]);
         chk("wr_wen", {31'd0, log_wen[i]}, 1);
      end
      for (int i = 0; i <= v.len; i++) begin
         ref_mem[(v.addr + i) % 32] = d[i];
         known[(v.addr + i) % 32]   = 1'b1;
      end
   endtask

   task automatic do_read(input vec_t v, input bit rnd);
      int          got = 0, t = 0, stall_left = v.stall_cyc, last_cyc = 0, rd0 = 0, idx;
      logic [31:0] held = '0;
      clear_log();
      do_req(1'b0, v.addr, v.len);
      while (got <= v.len && t < 2000) begin
         if (o_rdata_valid) begin
            if (got == v.stall_beat && stall_left > 0) begin
               if (stall_left == v.stall_cyc) begin
                  held = o_rdata;
                  rd0  = log_addr.size();
               end else begin
                  chk("stall_rdata_hold", o_rdata, held);
               end
               i_rdata_ready = 1'b0;
               stall_left--;
            end else if (rnd && $urandom_range(0, 2) == 0) begin
               i_rdata_ready = 1'b0;
            end else begin
               i_rdata_ready = 1'b1;
               if (v.stall_cyc > 0 && got == v.stall_beat) begin
                  chk("stall_no_strobe", log_addr.size(), rd0);
                  chk("stall_rdata_hold", o_rdata, held);
               end
               idx = (v.addr + got) % 32;
               if (known[idx]) chk("rdata", o_rdata, ref_mem[idx]);
               if (!rnd && v.stall_cyc == 0 && got > 0) chk("rd_beat_gap", cyc - last_cyc, 3);
               last_cyc = cyc;
               got++;
            end
         end else begin
            i_rdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         tick();
         t++;
      end
      i_rdata_ready = 1'b0;
      chk("rd_beats", got, v.len + 1);
      chk("rd_end_busy", {31'd0, o_busy}, 0);
      chk("rd_end_req_ready", {31'd0, o_req_ready}, 1);
      repeat (3) tick();
      chk("rd_strobe_count", log_addr.size(), v.exp_beats);
      if (log_addr.size() > 0) chk("rd_last_addr", log_addr[$], v.exp_last);
      for (int i = 0; i < log_addr.size() && i <= v.len; i++) begin
         chk("rd_addr", log_addr[i], (v.addr + i) % 32);
         chk("rd_wen", {31'd0, log_wen[i]}, 0);
      end
   endtask

   task automatic run(input vec_t v, input bit rnd);
      if (v.wr) do_write(v, rnd);
      else      do_read(v, rnd);
   endtask

`ifdef SRAM_CTRL_INIT_EN
   task automatic init_seq();
      int t = 0;
      clear_log();
      while (!o_init_done && t < 200) begin
         chk("init_req_ready_low", {31'd0, o_req_ready}, 0);
         tick();
         t++;
      end
      chk("init_done", {31'd0, o_init_done}, 1);
      chk("init_strobe_count", log_addr.size(), 32);
      for (int i = 0; i < log_addr.size() && i < 32; i++) begin
         chk("init_addr", log_addr[i], i);
         chk("init_data", log_data[i], 0);
      end
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = '0;
         known[i]   = 1'b1;
      end
   endtask
`endif

   task automatic post_reset();
`ifdef SRAM_CTRL_INIT_EN
      init_seq();
`else
      tick();
`endif
      chk("req_ready_after_reset", {31'd0, o_req_ready}, 1);
      chk("init_done_after_reset", {31'd0, o_init_done}, 1);
      chk("busy_after_reset", {31'd0, o_busy}, 0);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 32; i++) begin
         known[i]   = 1'b0;
         ref_mem[i] = '0;
      end
      //        wr    addr len base          sbeat scyc beats last
      tbl[0] = '{1'b1,  0,  3, 32'h0000_00A0, -1, 0,  4,  3};
      tbl[1] = '{1'b0,  0,  3, 32'h0,         -1, 0,  4,  3};
      tbl[2] = '{1'b1, 30,  3, 32'h0000_00B0, -1, 0,  4,  1};
      tbl[3] = '{1'b0, 30,  3, 32'h0,         -1, 0,  4,  1};
      tbl[4] = '{1'b0,  0,  2, 32'h0,          1, 5,  3,  2};
      tbl[5] = '{1'b1, 31,  0, 32'h0000_00C0, -1, 0,  1, 31};
      tbl[6] = '{1'b0, 31,  0, 32'h0,         -1, 0,  1, 31};
      tbl[7] = '{1'b1, 20, 15, 32'h0000_0100, -1, 0, 16,  3};
      tbl[8] = '{1'b0, 20, 15, 32'h0,         -1, 0, 16,  3};
      tbl[9] = '{1'b0,  5,  3, 32'h0,         -1, 0,  4,  8};

      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_cen", {31'd0, o_sram_cen}, 0);
      chk("rst_wen", {31'd0, o_sram_wen}, 0);
      chk("rst_oen", {31'd0, o_sram_oen}, 0);
      chk("rst_addr", {27'd0, o_sram_addr}, 0);
      chk("rst_data", o_sram_data, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_rdata_valid", {31'd0, o_rdata_valid}, 0);
      chk("rst_req_ready", {31'd0, o_req_ready}, 0);
      chk("rst_wdata_ready", {31'd0, o_wdata_ready}, 0);
      chk("rst_busy", {31'd0, o_busy}, 0);
`ifdef SRAM_CTRL_INIT_EN
      chk("rst_init_done", {31'd0, o_init_done}, 0);
`else
      chk("rst_init_done", {31'd0, o_init_done}, 1);
`endif
      rst_n = 1'b1;
      post_reset();
`ifdef SRAM_CTRL_INIT_EN
      run(tbl[9], 1'b0);
`endif

      for (int i = 0; i < 9; i++) run(tbl[i], 1'b0);

      // Reset in the middle of a 4-beat write, right after beat 2 is issued.
      clear_log();
      do_req(1'b1, 8, 3);
      for (int i = 0; i < 2; i++) begin
         chk("wdata_ready", {31'd0, o_wdata_ready}, 1);
         i_wdata_valid = 1'b1;
         i_wdata       = 32'hDEAD_0000 + 32'(i);
         tick();
         i_wdata_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_cen", {31'd0, o_sram_cen}, 0);
      chk("midrst_wen", {31'd0, o_sram_wen}, 0);
      chk("midrst_addr", {27'd0, o_sram_addr}, 0);
      chk("midrst_data", o_sram_data, 0);
      chk("midrst_busy", {31'd0, o_busy}, 0);
      chk("midrst_wdata_ready", {31'd0, o_wdata_ready}, 0);
      known[8] = 1'b0;
      known[9] = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      post_reset();
      v = '{1'b1, 8, 3, 32'h0000_00D0, -1, 0, 4, 11};
      run(v, 1'b0);
      v = '{1'b0, 8, 3, 32'h0, -1, 0, 4, 11};
      run(v, 1'b0);

      // Fill the whole memory, then random bursts against the model.
      v = '{1'b1, 0, 15, 32'h0, -1, 0, 16, 15};
      run(v, 1'b1);
      v = '{1'b1, 16, 15, 32'h0, -1, 0, 16, 31};
      run(v, 1'b1);
      for (int k = 0; k < 24; k++) begin
         v.wr         = 1'($urandom_range(0, 1));
         v.addr       = int'($urandom_range(0, 31));
         v.len        = int'($urandom_range(0, 15));
         v.base       = '0;
         v.stall_beat = -1;
         v.stall_cyc  = 0;
         v.exp_beats  = v.len + 1;
         v.exp_last   = (v.addr + v.len) % 32;
         run(v, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
